seg7_scan_controller: RTL and testbench

Parametrised multiplexed seven-segment scan controller, successor to the fixed 4-digit stopwatch display driver. It sits between the stopwatch counters and the board's common-anode display. It drives N digits from a packed BCD/hex bus, with per-digit decimal points, blank and blink masks, and leading-zero suppression. It adds an anti-ghosting blank guard, PWM brightness, and a frame-coherent input snapshot.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_decode.sv | 33 +++
 rtl/seg7_scan_controller.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: segment bit order
// and the active-low glyph constants for hex digits 0..F.
package seg7_pkg;

    // Position of each segment inside a 7-bit pattern (bit 0 = a ... bit 6 = g).
    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_bit_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A_HEX = 7'h08;
    localparam logic [6:0] SEG_B_HEX = 7'h03;
    localparam logic [6:0] SEG_C_HEX = 7'h46;
    localparam logic [6:0] SEG_D_HEX = 7'h21;
    localparam logic [6:0] SEG_E_HEX = 7'h06;
    localparam logic [6:0] SEG_F_HEX = 7'h0E;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-low seven-segment pattern
// (0-9 as numerals, 10-15 as A, b, C, d, E, F).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        case (value)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: pattern = SEG_A_HEX;
            4'hB: pattern = SEG_B_HEX;
            4'hC: pattern = SEG_C_HEX;
            4'hD: pattern = SEG_D_HEX;
            4'hE: pattern = SEG_E_HEX;
            4'hF: pattern = SEG_F_HEX;
            default: pattern = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// Multiplexed N-digit seven-segment scanner with frame snapshot, leading-zero
// suppression, blink, PWM brightness and an all-off guard at each digit change.
module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_DIV    = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      lz_suppress,
    input  logic [BRIGHT_W-1:0]       brightness,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [6:0]                segments,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int DWELL_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(REFRESH_DIV - 1);
    localparam logic [DWELL_W-1:0] GUARD_END  = DWELL_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [DWELL_W-1:0]      dwell_cnt;
    logic [IDX_W-1:0]        idx;
    logic [BRIGHT_W-1:0]     pwm_cnt;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    blink_phase;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic                    sh_lz;

    logic                    snap_now;
    logic                    dwell_wrap;
    logic                    frame_end;
    logic [4*NUM_DIGITS-1:0] view_digits;
    logic [NUM_DIGITS-1:0]   view_dp;
    logic [NUM_DIGITS-1:0]   view_blank;
    logic [NUM_DIGITS-1:0]   view_blink;
    logic                    view_lz;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    nz_seen;
    logic [3:0]              cur_digit;
    logic [6:0]              cur_pattern;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   anode_d;
    logic [6:0]              segments_d;
    logic                    dp_d;

    assign snap_now   = (idx == '0) && (dwell_cnt == '0);
    assign dwell_wrap = (dwell_cnt == DWELL_LAST);
    assign frame_end  = dwell_wrap && (idx == IDX_LAST);

    // The snapshot cycle itself is an output cycle of digit 0, so it must
    // already see the values being captured, not the previous frame's.
    assign view_digits = snap_now ? digits_in   : sh_digits;
    assign view_dp     = snap_now ? dp_in       : sh_dp;
    assign view_blank  = snap_now ? blank_mask  : sh_blank;
    assign view_blink  = snap_now ? blink_mask  : sh_blink;
    assign view_lz     = snap_now ? lz_suppress : sh_lz;

    always_comb begin
        nz_seen = 1'b0;
        lz_mask = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (view_digits[4*k +: 4] != 4'h0) nz_seen = 1'b1;
            lz_mask[k] = view_lz && !nz_seen;
        end
    end

    assign cur_digit = view_digits[{idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .value   (cur_digit),
        .pattern (cur_pattern)
    );

    assign lit = (dwell_cnt >= GUARD_END) && (pwm_cnt < brightness) &&
                 !view_blank[idx] && !(view_blink[idx] && blink_phase);

    always_comb begin
        anode_d    = '1;
        segments_d = SEG_OFF;
        dp_d       = 1'b1;
        if (lit) begin
            anode_d[idx] = 1'b0;
            segments_d   = lz_mask[idx] ? SEG_OFF : cur_pattern;
            dp_d         = ~view_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_cnt   <= '0;
            idx         <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (dwell_wrap) begin
                dwell_cnt <= '0;
                idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
            if (frame_end) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_blink  <= '0;
            sh_lz     <= 1'b0;
        end else if (snap_now) begin
            sh_digits <= digits_in;
            sh_dp     <= dp_in;
            sh_blank  <= blank_mask;
            sh_blink  <= blink_mask;
            sh_lz     <= lz_suppress;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anode       <= '1;
            segments    <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            anode       <= anode_d;
            segments    <= segments_d;
            dp          <= dp_d;
            frame_start <= snap_now;
        end
    end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed and randomised scan sequences for seg7_scan_controller, checked
// cycle by cycle against a time-indexed display model through an expected queue.
`timescale 1ns/1ps
module tb_seg7_scan_controller;

    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BC = 1;
    localparam int BW = 2;
    localparam int BD = 2;
    localparam logic [12:0] RESET_WORD = {4'hF, 7'h7F, 1'b1, 1'b0};

    // clock / reset
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [4*N-1:0] digits_in;
    logic [N-1:0]   dp_in;
    logic [N-1:0]   blank_mask;
    logic [N-1:0]   blink_mask;
    logic           lz_suppress;
    logic [BW-1:0]  brightness;
    logic [N-1:0]   anode;
    logic [6:0]     segments;
    logic           dp;
    logic           frame_start;

    seg7_scan_controller #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC),
        .BRIGHT_W     (BW),
        .BLINK_DIV    (BD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .anode       (anode),
        .segments    (segments),
        .dp          (dp),
        .frame_start (frame_start)
    );

    // scoreboard: word = {anode, segments, dp, frame_start}
    logic [12:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int c           = 0;

    logic [4*N-1:0] snap_digits;
    logic [N-1:0]   snap_dp;
    logic [N-1:0]   snap_blank;
    logic [N-1:0]   snap_blink;
    logic           snap_lz;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] hi;
        case (v)
            4'h0: hi = 7'h3F;  4'h1: hi = 7'h06;  4'h2: hi = 7'h5B;  4'h3: hi = 7'h4F;
            4'h4: hi = 7'h66;  4'h5: hi = 7'h6D;  4'h6: hi = 7'h7D;  4'h7: hi = 7'h07;
            4'h8: hi = 7'h7F;  4'h9: hi = 7'h6F;  4'hA: hi = 7'h77;  4'hB: hi = 7'h7C;
            4'hC: hi = 7'h39;  4'hD: hi = 7'h5E;  4'hE: hi = 7'h79;  default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    // Expected output after the coming edge, derived from cycles since release.
    task automatic predict();
        int dwell, pos, frame, pwm, msd;
        bit phase, on, fs;
        logic [3:0] an;
        logic [6:0] sg;
        logic       d;
        dwell = c % RD;
        pos   = (c / RD) % N;
        frame = c / (RD * N);
        pwm   = c % (1 << BW);
        phase = ((frame / BD) % 2) == 1;
        fs    = (c % (RD * N)) == 0;
        if (fs) begin
            snap_digits = digits_in;
            snap_dp     = dp_in;
            snap_blank  = blank_mask;
            snap_blink  = blink_mask;
            snap_lz     = lz_suppress;
        end
        msd = -1;
        for (int k = 0; k < N; k++)
            if (snap_digits[4*k +: 4] != 4'h0) msd = k;
        on = (dwell >= BC) && (pwm < int'(brightness)) && !snap_blank[pos] &&
             !(snap_blink[pos] && phase);
        an = 4'hF;
        sg = 7'h7F;
        d  = 1'b1;
        if (on) begin
            an[pos] = 1'b0;
            sg = (snap_lz && pos > msd && pos != 0) ? 7'h7F : glyph(snap_digits[4*pos +: 4]);
            d  = ~snap_dp[pos];
        end
        exp_q.push_back({an, sg, d, fs});
    endtask

    task automatic compare(input string tag);
        logic [12:0] got, want;
        got  = {anode, segments, dp, frame_start};
        want = exp_q.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s c=%0d observed=%h expected=%h", tag, c, got, want);
        end
    endtask

    // driver tasks
    task automatic step(input string tag);
        predict();
        @(posedge clk);
        #1;
        compare(tag);
        c++;
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic check_reset(input string tag);
        exp_q.push_back(RESET_WORD);
        compare(tag);
    endtask

    initial begin
        digits_in   = 16'h1234;
        dp_in       = '0;
        blank_mask  = '0;
        blink_mask  = '0;
        lz_suppress = 1'b0;
        brightness  = 2'd3;

        #12;
        check_reset("reset_hold");
        @(posedge clk);
        #1;
        check_reset("reset_hold_edge");
        #1;
        reset = 1'b1;
        c     = 0;

        run(64, "scan_1234");

        run(19, "snap_pre");
        digits_in = 16'h5678;
        run(13, "snap_frame_tail");
        run(32, "snap_next_frame");

        lz_suppress = 1'b1;
        digits_in   = 16'h0070;
        dp_in       = 4'b1000;
        run(64, "lz_0070");
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        run(64, "lz_0000");

        lz_suppress = 1'b0;
        digits_in   = 16'h1234;
        brightness  = 2'd1;
        run(32, "bright_1");
        brightness = 2'd0;
        run(32, "bright_0");
        brightness = 2'd3;
        blank_mask = 4'b0010;
        run(64, "blank_d1");
        blank_mask = 4'b0000;

        blink_mask = 4'b0001;
        run(160, "blink_d0");
        blink_mask = 4'b0000;

        for (int f = 0; f < 6; f++) begin
            digits_in   = 16'($urandom_range(0, 65535));
            dp_in       = 4'($urandom_range(0, 15));
            lz_suppress = 1'($urandom_range(0, 1));
            brightness  = 2'($urandom_range(1, 3));
            run($urandom_range(5, 40), "random");
        end
        digits_in   = 16'h00A0;
        lz_suppress = 1'b1;
        brightness  = 2'd3;
        run(64, "hex_lz");

        while ((c % (RD * N)) != 2 * RD + 3) step("align");
        #1;
        reset = 1'b0;
        #1;
        check_reset("async_reset");
        @(posedge clk);
        #1;
        check_reset("reset_held");
        #1;
        digits_in   = 16'hABCD;
        lz_suppress = 1'b0;
        dp_in       = 4'b0101;
        reset       = 1'b1;
        c           = 0;
        run(64, "restart");

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
